// File: rtl/row_prefetch.sv
// row_prefetch: double-buffered row fetcher streaming a 1bpp front row while the back row fills
module row_prefetch #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  parameter int WORDS  = WIDTH / 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x_pos,
  input  logic        blank,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        next_row,
  input  logic        vsync_pulse,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [9:0]  req_row,
  output logic [5:0]  req_word,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_data,
  output logic        pixel,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        blank_o,
  output logic        underflow
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state_q, state_d;
  logic [5:0]  word_q, word_d;
  logic [9:0]  req_row_q, req_row_d, fetch_row_q, fetch_row_d, row_nxt;
  logic        fill_done_q, fill_done_d, consumed_q, consumed_d;
  logic        front_sel_q, front_sel_d, underflow_q, underflow_d;
  logic        discard_q, discard_d;
  logic        pixel_q, hsync_q, vsync_q, blank_q;
  logic        wr_en, fill_now, swap, restart_wait;
  logic [15:0] rd_word;
  logic [15:0] buf_q [2][WORDS];

  assign wr_en        = state_q == WAIT && rsp_valid && !discard_q && !vsync_pulse;
  assign fill_now     = wr_en && word_q == 6'(WORDS - 1);
  assign swap         = next_row && !vsync_pulse && consumed_q && (fill_done_q || fill_now);
  assign row_nxt      = fetch_row_q + 10'd1;
  // a request already accepted by memory must have its response drained before restarting
  assign restart_wait = (state_q == WAIT && !rsp_valid) || (state_q == REQ && req_ready);
  assign rd_word      = (x_pos[9:4] < 6'(WORDS)) ? buf_q[front_sel_q][x_pos[9:4]] : '0;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    req_row_d   = req_row_q;
    fetch_row_d = fetch_row_q;
    fill_done_d = fill_done_q | fill_now;
    consumed_d  = consumed_q | ~blank;
    front_sel_d = front_sel_q;
    discard_d   = discard_q;
    underflow_d = underflow_q | (next_row && !vsync_pulse && consumed_q && !(fill_done_q || fill_now));
    if (state_q == REQ && req_ready) state_d = WAIT;
    if (state_q == WAIT && rsp_valid) begin
      state_d   = fill_now ? IDLE : REQ;
      word_d    = (discard_q || fill_now) ? word_q : word_q + 6'd1;
      discard_d = 1'b0;
    end
    if (swap) begin
      front_sel_d = ~front_sel_q;
      fill_done_d = 1'b0;
      consumed_d  = 1'b0;
      fetch_row_d = row_nxt;
      if (row_nxt < 10'(HEIGHT)) begin
        state_d   = REQ;
        word_d    = '0;
        req_row_d = row_nxt;
      end
    end
    if (vsync_pulse) begin
      fetch_row_d = '0;
      consumed_d  = 1'b1;
      fill_done_d = 1'b0;
      word_d      = '0;
      req_row_d   = '0;
      state_d     = restart_wait ? WAIT : REQ;
      discard_d   = restart_wait;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      req_row_q   <= '0;
      fetch_row_q <= '0;
      fill_done_q <= 1'b0;
      consumed_q  <= 1'b0;
      front_sel_q <= 1'b0;
      underflow_q <= 1'b0;
      discard_q   <= 1'b0;
      pixel_q     <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      blank_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      req_row_q   <= req_row_d;
      fetch_row_q <= fetch_row_d;
      fill_done_q <= fill_done_d;
      consumed_q  <= consumed_d;
      front_sel_q <= front_sel_d;
      underflow_q <= underflow_d;
      discard_q   <= discard_d;
      pixel_q     <= ~blank & rd_word[~x_pos[3:0]];
      hsync_q     <= hsync;
      vsync_q     <= vsync;
      blank_q     <= blank;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[~front_sel_q][word_q] <= rsp_data;
  end

  assign req_valid = state_q == REQ;
  assign req_row   = req_row_q;
  assign req_word  = word_q;
  assign pixel     = pixel_q;
  assign hsync_o   = hsync_q;
  assign vsync_o   = vsync_q;
  assign blank_o   = blank_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_row_prefetch.sv
// tb_row_prefetch: random-stimulus bench with a row-level reference model of row_prefetch
module tb_row_prefetch;
  localparam int WIDTH = 800, HEIGHT = 600, WORDS = 50;
  logic clk = 0, reset = 1;
  logic [9:0] x_pos = '0;
  logic blank = 1, hsync = 0, vsync = 0, next_row = 0, vsync_pulse = 0;
  logic req_valid, req_ready = 1, rsp_valid = 0;
  logic [9:0] req_row;
  logic [5:0] req_word;
  logic [15:0] rsp_data = '0;
  logic pixel, hsync_o, vsync_o, blank_o, underflow;

  always #5 clk = ~clk;

  row_prefetch dut (
    .clk(clk), .reset(reset), .x_pos(x_pos), .blank(blank), .hsync(hsync), .vsync(vsync),
    .next_row(next_row), .vsync_pulse(vsync_pulse), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_word(req_word), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .pixel(pixel), .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o), .underflow(underflow)
  );

  int n_tests = 0, n_fail = 0;
  logic [15:0] front_m [WORDS];
  logic [15:0] back_m [WORDS];
  bit front_known, m_active, m_consumed, m_under, out_busy, out_stale;
  int m_row, m_filled;
  int ready_pct = 100, lat_max = 1, mem_mode = 0, rsp_cnt = 0;
  bit rsp_busy, spur_en = 1;
  logic [15:0] rsp_next;
  int n_hs, n_starts, last_row, last_word, n_ones;
  bit count_ones, hold_en, hold_hit, after_vs, restart_seen;

  task automatic chk(string tag, longint got, longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_data(logic [9:0] r, logic [5:0] w);
    case (mem_mode)
      1: return 16'h8000;
      2: return {10'd0, w};
      default: return 16'({r, w} * 16'd40503) ^ 16'h5a3c;
    endcase
  endfunction

  function automatic void model_reset();
    m_active = 0; m_consumed = 0; m_under = 0; out_busy = 0; out_stale = 0;
    m_row = 0; m_filled = 0; front_known = 0;
  endfunction

  task automatic step();
    bit hs, p_rv, p_vs, p_nr, p_bl, p_hs, p_vsy, p_rst, swp, pix_known;
    logic [9:0] p_row, p_x;
    logic [5:0] p_word;
    logic [15:0] p_rd;
    logic exp_pix;
    int idx;
    hs = req_valid && req_ready; p_row = req_row; p_word = req_word;
    p_rv = rsp_valid; p_rd = rsp_data; p_vs = vsync_pulse; p_nr = next_row;
    p_bl = blank; p_hs = hsync; p_vsy = vsync; p_x = x_pos; p_rst = reset;
    idx = int'(p_x[9:4]);
    pix_known = p_bl || idx >= WORDS || front_known;
    exp_pix = (!p_bl && idx < WORDS && front_known) ? front_m[idx][15 - int'(p_x[3:0])] : 1'b0;
    @(posedge clk); #1;
    next_row = 0; vsync_pulse = 0;
    if (p_rst) model_reset();
    else begin
      // responses belong to earlier requests, so retire them before logging a new one
      if (p_vs) out_stale = 1;
      if (p_rv && out_busy) begin
        out_busy = 0;
        if (!out_stale && m_filled < WORDS) begin back_m[m_filled] = p_rd; m_filled++; end
      end
      if (hs) begin
        n_hs++; last_row = p_row; last_word = p_word;
        if (p_word == 0) n_starts++;
        chk("req_row", p_row, m_row);
        chk("req_word", p_word, m_filled);
        if (after_vs) begin
          chk("restart_row", p_row, 0);
          chk("restart_word", p_word, 0);
          after_vs = 0; restart_seen = 1;
        end
        if (hold_en && p_row == 7 && p_word == 20) hold_hit = 1;
        out_busy = 1; out_stale = p_vs;
      end
      swp = 0;
      if (p_vs) begin m_row = 0; m_consumed = 1; m_filled = 0; m_active = 1; end
      else begin
        if (p_nr && m_consumed) begin
          if (m_filled == WORDS) begin
            front_m = back_m; front_known = 1; m_consumed = 0; m_row++;
            m_filled = 0; m_active = m_row < HEIGHT; swp = 1;
          end else m_under = 1;
        end
        if (!p_bl && !swp) m_consumed = 1;
      end
    end
    if (p_rst || pix_known) chk("pixel", pixel, p_rst ? 1'b0 : exp_pix);
    chk("hsync_o", hsync_o, p_rst ? 1'b0 : p_hs);
    chk("vsync_o", vsync_o, p_rst ? 1'b0 : p_vsy);
    chk("blank_o", blank_o, p_rst ? 1'b1 : p_bl);
    chk("underflow", underflow, m_under);
    chk("req_valid", req_valid, m_active && m_filled < WORDS && !out_busy);
    if (p_rst) begin chk("rst_req_row", req_row, 0); chk("rst_req_word", req_word, 0); end
    if (count_ones) n_ones += int'(pixel);
    rsp_valid = 0;
    rsp_data = 16'($urandom);
    if (p_rst || reset) rsp_busy = 0;
    else begin
      if (hs) begin
        rsp_busy = 1; rsp_next = mem_data(p_row, p_word);
        rsp_cnt = (hold_en && !restart_seen && p_row == 7 && p_word == 20) ? 6 : $urandom_range(lat_max, 1);
      end
      if (rsp_busy) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin rsp_valid = 1; rsp_data = rsp_next; rsp_busy = 0; end
      end else if (!hs && spur_en && $urandom_range(9, 0) == 0) rsp_valid = 1;
    end
    req_ready = $urandom_range(99, 0) < ready_pct;
  endtask

  task automatic line(int act, int total, bit nr, bit rnd);
    for (int c = 0; c < total; c++) begin
      blank = c >= act;
      x_pos = blank ? 10'd0 : (rnd ? 10'($urandom_range(WIDTH - 1, 0)) : 10'(c));
      hsync = c >= total - 8 && c < total - 4;
      vsync = 1'($urandom_range(1, 0));
      next_row = nr && c == total - 1;
      if (hold_en && hold_hit && !after_vs && !restart_seen) begin vsync_pulse = 1; after_vs = 1; end
      step();
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin blank = 1; x_pos = 0; step(); end
  endtask

  initial begin
    int n0;
    model_reset();
    idle(3);
    reset = 0;
    idle(2);
    // single row fetch with word-index data and a one-cycle memory
    mem_mode = 2; ready_pct = 100; lat_max = 1; n_hs = 0;
    vsync_pulse = 1;
    idle(120);
    chk("row0_req_count", n_hs, 50);
    chk("row0_last_word", last_word, 49);
    chk("row0_last_row", last_row, 0);
    idle(20);
    chk("row0_no_more_req", n_hs, 50);
    // row 0 of 0x8000 words shown on the first active line
    mem_mode = 1;
    vsync_pulse = 1;
    line(0, 120, 1, 0);
    n_ones = 0; count_ones = 1;
    line(800, 820, 1, 0);
    count_ones = 0;
    chk("msb_pixel_count", n_ones, 50);
    // stalled memory: row repeats and underflow sticks
    mem_mode = 0; ready_pct = 0;
    vsync_pulse = 1;
    for (int k = 0; k < 3; k++) begin
      line(40, 60, 1, 0);
      chk("stall_underflow", underflow, 1);
    end
    // random handshakes; frame restart while row 7 word 20 is pending
    ready_pct = 70; lat_max = 3; hold_en = 1;
    vsync_pulse = 1;
    for (int k = 0; k < 40 && !restart_seen; k++) line(16, 300, 1, 1);
    chk("restart_seen", restart_seen, 1);
    hold_en = 0;
    line(16, 300, 1, 1);
    // asynchronous reset in the middle of a fetch
    ready_pct = 100; lat_max = 1;
    vsync_pulse = 1;
    idle(31);
    #2 reset = 1; #1;
    chk("async_req_valid", req_valid, 0);
    chk("async_req_row", req_row, 0);
    chk("async_req_word", req_word, 0);
    chk("async_pixel", pixel, 0);
    chk("async_hsync_o", hsync_o, 0);
    chk("async_vsync_o", vsync_o, 0);
    chk("async_blank_o", blank_o, 1);
    chk("async_underflow", underflow, 0);
    idle(2);
    reset = 0;
    n0 = n_hs;
    idle(40);
    chk("no_req_after_reset", n_hs - n0, 0);
    // full frame with a responsive memory
    n_starts = 0;
    vsync_pulse = 1;
    line(0, 104, 1, 0);
    for (int k = 0; k < HEIGHT; k++) line($urandom_range(16, 1), 104, k < HEIGHT - 1, 1);
    chk("frame_row_fetches", n_starts, 600);
    chk("frame_last_row", last_row, 599);
    chk("frame_underflow", underflow, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
